// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 encryption sequencer: whitening, 10 rounds, key schedule
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] cyphertext
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SB   = 2'b01;
  localparam logic [1:0] MR   = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [1:0]   st;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] state_reg;
  logic [127:0] rkey_reg;
  logic [127:0] sb_reg;
  logic [31:0]  sw_reg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte (r,c) lives at index r+4c; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] next_key;
  logic [127:0] sr_out;
  logic [127:0] round_out;
  logic         round_ok;
  logic         last_round;

  always_comb begin
    w4         = rkey_reg[127:96] ^ sw_reg ^ {rcon, 24'h0};
    w5         = rkey_reg[95:64] ^ w4;
    w6         = rkey_reg[63:32] ^ w5;
    w7         = rkey_reg[31:0] ^ w6;
    next_key   = {w4, w5, w6, w7};
    last_round = (round == LAST_ROUND);
    round_ok   = (round != 4'd0) && (round <= LAST_ROUND);
    sr_out     = shift_rows(sb_reg);
    round_out  = (last_round ? sr_out : mix_columns(sr_out)) ^ next_key;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      round      <= 4'd0;
      rcon       <= 8'h01;
      state_reg  <= 128'h0;
      rkey_reg   <= 128'h0;
      sb_reg     <= 128'h0;
      sw_reg     <= 32'h0;
      cyphertext <= 128'h0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (load) begin
            state_reg <= plaintext ^ key;
            rkey_reg  <= key;
            round     <= 4'd1;
            rcon      <= 8'h01;
            st        <= SB;
          end
        end
        SB: begin
          if (!round_ok) begin
            st <= DONE;
          end else begin
            sb_reg <= sub_bytes(state_reg);
            sw_reg <= sub_word({rkey_reg[23:0], rkey_reg[31:24]});
            st     <= MR;
          end
        end
        default: begin
          if (!round_ok) begin
            st <= DONE;
          end else begin
            state_reg <= round_out;
            rkey_reg  <= next_key;
            rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            // The counter saturates at the final round so it never exceeds NR
            if (last_round) begin
              cyphertext <= round_out;
              st         <= DONE;
            end else begin
              round <= round + 4'd1;
              st    <= SB;
            end
          end
        end
      endcase
    end
  end

  assign busy = (st == SB) || (st == MR);
  assign done = (st == DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed FIPS-197 vectors and multi-cycle corner cases for aes_round_ctrl
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] key = 128'h0;
  logic [127:0] plaintext = 128'h0;
  logic         busy;
  logic         done;
  logic [127:0] cyphertext;

  int errors = 0;
  int checks = 0;

  aes_round_ctrl dut (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .plaintext(plaintext),
    .busy(busy), .done(done), .cyphertext(cyphertext)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for done after an accepting edge; returns cycles taken and whether busy stayed high
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_vec(input string nm, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] ct);
    int   n;
    logic bok;
    @(negedge clk);
    key = k; plaintext = p; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check({nm, " busy_after_accept"}, 128'(busy), 128'(1));
    wait_done(n, bok);
    check({nm, " latency"}, 128'(n), 128'(20));
    check({nm, " busy_through_run"}, 128'(bok), 128'(1));
    check({nm, " cyphertext"}, cyphertext, ct);
    check({nm, " busy_at_done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    vec_t vecs[3];
    int   n;
    logic bok;

    vecs[0] = '{"fips_b",   KEY_B,  PT_B,   CT_B};
    vecs[1] = '{"all_zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[2] = '{"fips_c1",  KEY_C,  PT_C,   CT_C};

    // Reset held with load asserted; encryption starts on the first edge after release
    key = KEY_B; plaintext = PT_B; load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset done", 128'(done), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset cyphertext", cyphertext, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("release busy", 128'(busy), 128'(1));
    wait_done(n, bok);
    check("release latency", 128'(n), 128'(20));
    check("release cyphertext", cyphertext, CT_B);

    for (int i = 0; i < 3; i++) run_vec(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct);
    check("c1 final round key", dut.rkey_reg, RK_C);

    // Idle with load low holds the result
    repeat (3) @(posedge clk);
    #1;
    check("hold cyphertext", cyphertext, CT_C);
    check("hold done", 128'(done), 128'(1));

    // Load pulses with other inputs mid-run are ignored
    @(negedge clk);
    key = KEY_B; plaintext = PT_B; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 5 || n == 18) begin key = KEY_C; plaintext = PT_C; load = 1'b1; end
      if (n == 6 || n == 19) load = 1'b0;
    end
    check("busy_load latency", 128'(n), 128'(20));
    check("busy_load cyphertext", cyphertext, CT_B);

    // Reset in the middle of a C.1 run
    @(negedge clk);
    key = KEY_C; plaintext = PT_C; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset state", 128'(dut.st), 128'(0));
    check("midreset cyphertext", cyphertext, 128'h0);
    check("midreset busy", 128'(busy), 128'(0));
    check("midreset done", 128'(done), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_vec("after_reset_c1", KEY_C, PT_C, CT_C);

    // Back-to-back with load held high
    @(negedge clk);
    key = KEY_B; plaintext = PT_B; load = 1'b1;
    @(posedge clk); #1;
    wait_done(n, bok);
    check("b2b first latency", 128'(n), 128'(20));
    check("b2b first cyphertext", cyphertext, CT_B);
    key = KEY_C; plaintext = PT_C;
    @(posedge clk); #1;
    check("b2b done one cycle", 128'(done), 128'(0));
    check("b2b restart busy", 128'(busy), 128'(1));
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) check("b2b old result held", cyphertext, CT_B);
    end
    check("b2b second latency", 128'(n), 128'(20));
    check("b2b second cyphertext", cyphertext, CT_C);
    load = 1'b0;
    @(posedge clk); #1;
    check("b2b done stays", 128'(done), 128'(1));
    check("b2b result stays", cyphertext, CT_C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
